store_buffer_coalescing: RTL and testbench

Parametrised successor to the core's store buffer. It sits between the LSU execute stage, the commit stage and the data bus. It holds speculative and committed stores in a circular queue and drains committed stores in order as byte-masked bus writes, merging two adjacent committed stores to the same word into one write. It also serves load queries by byte-granular forwarding from all resident stores, with bus read-through for any bytes not covered.

---
 rtl/store_buffer_coalescing.sv | 246 ++++++++++++++++++++++++
 tb/tb_store_buffer_coalescing.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_coalescing.sv
// Coalescing store buffer: circular queue of speculative/committed stores, in-order
// byte-masked drain with adjacent same-word merge, and byte-granular load forwarding.
package store_buffer_coalescing_pkg;
  localparam int SB_COMMIT_WIDTH = 4;
  localparam int SB_ROB_ID_WIDTH = 7;

  typedef struct packed {
    logic                                             enable;
    logic                                             flush;
    logic [SB_COMMIT_WIDTH-1:0][SB_ROB_ID_WIDTH-1:0]  committed_rob_id;
    logic [SB_COMMIT_WIDTH-1:0]                       committed_rob_id_valid;
  } commit_feedback_pack_t;
endpackage

module store_buffer_coalescing
  import store_buffer_coalescing_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = SB_ROB_ID_WIDTH,
  parameter int COMMIT_WIDTH = SB_COMMIT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_stbuf_rd,
  input  logic [ADDR_WIDTH-1:0]     issue_stbuf_read_addr,
  input  logic [3:0]                issue_stbuf_read_size,
  output logic [DATA_WIDTH-1:0]     stbuf_exlsu_bus_data,
  output logic [DATA_WIDTH/8-1:0]   stbuf_exlsu_fwd_mask,
  output logic                      stbuf_exlsu_bus_ready,
  input  logic                      exlsu_stbuf_push,
  input  logic [ROB_ID_WIDTH-1:0]   exlsu_stbuf_rob_id,
  input  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_write_addr,
  input  logic [3:0]                exlsu_stbuf_write_size,
  input  logic [DATA_WIDTH-1:0]     exlsu_stbuf_write_data,
  output logic                      stbuf_exlsu_full,
  output logic                      stbuf_misaligned,
  input  commit_feedback_pack_t     commit_feedback_pack,
  output logic                      stbuf_bus_read_req,
  output logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr,
  output logic [3:0]                stbuf_bus_read_size,
  input  logic [DATA_WIDTH-1:0]     bus_stbuf_data,
  input  logic                      bus_stbuf_read_ack,
  output logic                      stbuf_bus_write_req,
  output logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
  output logic [DATA_WIDTH/8-1:0]   stbuf_bus_write_mask,
  output logic [DATA_WIDTH-1:0]     stbuf_bus_data,
  input  logic                      bus_stbuf_write_ack,
  output logic                      stbuf_all_empty
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW    = $clog2(DEPTH);
  localparam int PW    = IW + 1;
  localparam int LB    = $clog2(BYTES);
  localparam int WAW   = ADDR_WIDTH - LB;

  function automatic logic [BYTES-1:0] lane_mask(input logic [LB-1:0] lane, input logic [3:0] size);
    for (int b = 0; b < BYTES; b++)
      lane_mask[b] = (b >= int'(lane)) && (b < int'(lane) + int'(size));
  endfunction

  logic [DEPTH-1:0]        vld_q, vld_d, cmt_q, cmt_d;
  logic [ROB_ID_WIDTH-1:0] rob_q   [DEPTH];
  logic [ROB_ID_WIDTH-1:0] rob_d   [DEPTH];
  logic [WAW-1:0]          waddr_q [DEPTH];
  logic [WAW-1:0]          waddr_d [DEPTH];
  logic [BYTES-1:0]        mask_q  [DEPTH];
  logic [BYTES-1:0]        mask_d  [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q  [DEPTH];
  logic [DATA_WIDTH-1:0]   data_d  [DEPTH];
  logic [PW-1:0]           rptr_q, rptr_d, wptr_q, wptr_d;
  logic                    misal_q, misal_d;
  logic                    wr_busy_q, wr_busy_d, wr_pair_q, wr_pair_d;

  logic [IW-1:0]           head, head1;
  logic                    full, pair_cand, pair, wr_req;
  logic                    aligned, flush_now, push_ok;
  logic [PW-1:0]           ncmt;
  logic [LB-1:0]           push_lane;
  logic [BYTES-1:0]        push_mask;
  logic [DATA_WIDTH-1:0]   push_data;

  assign full            = (rptr_q ^ wptr_q) == {1'b1, {IW{1'b0}}};
  assign stbuf_exlsu_full = full;
  assign stbuf_all_empty  = (rptr_q == wptr_q);
  assign stbuf_misaligned = misal_q;

  assign head      = rptr_q[IW-1:0];
  assign head1     = head + IW'(1);
  assign wr_req    = vld_q[head] && cmt_q[head];
  assign pair_cand = vld_q[head1] && cmt_q[head1] && (waddr_q[head1] == waddr_q[head]);
  // Once a request is on the bus its shape is frozen so addr/mask/data stay stable until ack.
  assign pair      = wr_busy_q ? wr_pair_q : pair_cand;

  assign push_lane = exlsu_stbuf_write_addr[LB-1:0];
  assign aligned   = (exlsu_stbuf_write_size == 4'd1 || exlsu_stbuf_write_size == 4'd2 ||
                      exlsu_stbuf_write_size == 4'd4 || exlsu_stbuf_write_size == 4'd8) &&
                     (int'(exlsu_stbuf_write_size) <= BYTES) &&
                     ((exlsu_stbuf_write_addr[3:0] & (exlsu_stbuf_write_size - 4'd1)) == 4'd0);
  assign flush_now = commit_feedback_pack.enable && commit_feedback_pack.flush;
  assign push_ok   = exlsu_stbuf_push && !full && aligned && !flush_now;
  assign push_mask = lane_mask(push_lane, exlsu_stbuf_write_size);

  always_comb begin
    push_data = exlsu_stbuf_write_data << {push_lane, 3'b000};
    for (int b = 0; b < BYTES; b++)
      if (!push_mask[b]) push_data[8*b +: 8] = 8'h00;
  end

  always_comb begin
    vld_d   = vld_q;
    cmt_d   = cmt_q;
    rob_d   = rob_q;
    waddr_d = waddr_q;
    mask_d  = mask_q;
    data_d  = data_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    ncmt    = '0;

    if (commit_feedback_pack.enable)
      for (int e = 0; e < DEPTH; e++)
        for (int i = 0; i < COMMIT_WIDTH; i++)
          if (commit_feedback_pack.committed_rob_id_valid[i] && vld_q[e] && !cmt_q[e] &&
              rob_q[e] == commit_feedback_pack.committed_rob_id[i])
            cmt_d[e] = 1'b1;

    for (int e = 0; e < DEPTH; e++)
      if (vld_q[e] && cmt_d[e]) ncmt = ncmt + PW'(1);

    if (wr_req && bus_stbuf_write_ack) begin
      vld_d[head] = 1'b0;
      cmt_d[head] = 1'b0;
      if (pair) begin
        vld_d[head1] = 1'b0;
        cmt_d[head1] = 1'b0;
      end
      rptr_d = rptr_q + (pair ? PW'(2) : PW'(1));
    end

    if (flush_now) begin
      wptr_d = rptr_q + ncmt;
      for (int e = 0; e < DEPTH; e++)
        if (!cmt_d[e]) vld_d[e] = 1'b0;
    end else if (push_ok) begin
      vld_d[wptr_q[IW-1:0]]   = 1'b1;
      cmt_d[wptr_q[IW-1:0]]   = 1'b0;
      rob_d[wptr_q[IW-1:0]]   = exlsu_stbuf_rob_id;
      waddr_d[wptr_q[IW-1:0]] = exlsu_stbuf_write_addr[ADDR_WIDTH-1:LB];
      mask_d[wptr_q[IW-1:0]]  = push_mask;
      data_d[wptr_q[IW-1:0]]  = push_data;
      wptr_d = wptr_q + PW'(1);
    end
  end

  assign misal_d   = exlsu_stbuf_push && !full && !flush_now && !aligned;
  assign wr_busy_d = wr_req && !bus_stbuf_write_ack;
  assign wr_pair_d = pair;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      cmt_q     <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      misal_q   <= 1'b0;
      wr_busy_q <= 1'b0;
      wr_pair_q <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        rob_q[e]   <= '0;
        waddr_q[e] <= '0;
        mask_q[e]  <= '0;
        data_q[e]  <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      cmt_q     <= cmt_d;
      rob_q     <= rob_d;
      waddr_q   <= waddr_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      misal_q   <= misal_d;
      wr_busy_q <= wr_busy_d;
      wr_pair_q <= wr_pair_d;
    end
  end

  always_comb begin
    stbuf_bus_write_req  = wr_req;
    stbuf_bus_write_addr = '0;
    stbuf_bus_write_mask = '0;
    stbuf_bus_data       = '0;
    if (wr_req) begin
      stbuf_bus_write_addr = {waddr_q[head], {LB{1'b0}}};
      stbuf_bus_write_mask = pair ? (mask_q[head] | mask_q[head1]) : mask_q[head];
      for (int b = 0; b < BYTES; b++)
        stbuf_bus_data[8*b +: 8] = (pair && mask_q[head1][b]) ? data_q[head1][8*b +: 8]
                                                              : data_q[head][8*b +: 8];
    end
  end

  logic [BYTES-1:0]      ld_mask, fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [IW-1:0]         fidx;
  logic                  covered;

  // Walk oldest to youngest so the youngest matching entry wins each lane.
  always_comb begin
    ld_mask  = lane_mask(issue_stbuf_read_addr[LB-1:0], issue_stbuf_read_size);
    fwd_hit  = '0;
    fwd_data = '0;
    fidx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = head + IW'(k);
      for (int b = 0; b < BYTES; b++)
        if (vld_q[fidx] && mask_q[fidx][b] &&
            waddr_q[fidx] == issue_stbuf_read_addr[ADDR_WIDTH-1:LB]) begin
          fwd_hit[b]          = 1'b1;
          fwd_data[8*b +: 8]  = data_q[fidx][8*b +: 8];
        end
    end
    fwd_hit = fwd_hit & ld_mask;
    covered = (fwd_hit == ld_mask);

    stbuf_exlsu_fwd_mask  = '0;
    stbuf_exlsu_bus_data  = '0;
    stbuf_exlsu_bus_ready = 1'b0;
    stbuf_bus_read_req    = 1'b0;
    stbuf_bus_read_addr   = '0;
    stbuf_bus_read_size   = '0;
    if (issue_stbuf_rd) begin
      stbuf_exlsu_fwd_mask  = fwd_hit;
      stbuf_exlsu_bus_ready = covered || bus_stbuf_read_ack;
      for (int b = 0; b < BYTES; b++)
        stbuf_exlsu_bus_data[8*b +: 8] = fwd_hit[b] ? fwd_data[8*b +: 8] : bus_stbuf_data[8*b +: 8];
      if (!covered) begin
        stbuf_bus_read_req  = 1'b1;
        stbuf_bus_read_addr = issue_stbuf_read_addr;
        stbuf_bus_read_size = issue_stbuf_read_size;
      end
    end
  end
endmodule

// File: tb/tb_store_buffer_coalescing.sv
// Directed bench for store_buffer_coalescing: fill/drain, coalescing, forwarding,
// read-through, flush, misaligned push, reset mid-write and coalescing across wrap.
module tb_store_buffer_coalescing;
  import store_buffer_coalescing_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_stbuf_rd;
  logic [31:0] issue_stbuf_read_addr;
  logic [3:0]  issue_stbuf_read_size;
  logic [31:0] stbuf_exlsu_bus_data;
  logic [3:0]  stbuf_exlsu_fwd_mask;
  logic        stbuf_exlsu_bus_ready;
  logic        exlsu_stbuf_push;
  logic [6:0]  exlsu_stbuf_rob_id;
  logic [31:0] exlsu_stbuf_write_addr;
  logic [3:0]  exlsu_stbuf_write_size;
  logic [31:0] exlsu_stbuf_write_data;
  logic        stbuf_exlsu_full;
  logic        stbuf_misaligned;
  commit_feedback_pack_t cfp;
  logic        stbuf_bus_read_req;
  logic [31:0] stbuf_bus_read_addr;
  logic [3:0]  stbuf_bus_read_size;
  logic [31:0] bus_stbuf_data;
  logic        bus_stbuf_read_ack;
  logic        stbuf_bus_write_req;
  logic [31:0] stbuf_bus_write_addr;
  logic [3:0]  stbuf_bus_write_mask;
  logic [31:0] stbuf_bus_data;
  logic        bus_stbuf_write_ack;
  logic        stbuf_all_empty;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_buffer_coalescing dut (
    .clk(clk), .rst(rst),
    .issue_stbuf_rd(issue_stbuf_rd), .issue_stbuf_read_addr(issue_stbuf_read_addr),
    .issue_stbuf_read_size(issue_stbuf_read_size), .stbuf_exlsu_bus_data(stbuf_exlsu_bus_data),
    .stbuf_exlsu_fwd_mask(stbuf_exlsu_fwd_mask), .stbuf_exlsu_bus_ready(stbuf_exlsu_bus_ready),
    .exlsu_stbuf_push(exlsu_stbuf_push), .exlsu_stbuf_rob_id(exlsu_stbuf_rob_id),
    .exlsu_stbuf_write_addr(exlsu_stbuf_write_addr), .exlsu_stbuf_write_size(exlsu_stbuf_write_size),
    .exlsu_stbuf_write_data(exlsu_stbuf_write_data), .stbuf_exlsu_full(stbuf_exlsu_full),
    .stbuf_misaligned(stbuf_misaligned), .commit_feedback_pack(cfp),
    .stbuf_bus_read_req(stbuf_bus_read_req), .stbuf_bus_read_addr(stbuf_bus_read_addr),
    .stbuf_bus_read_size(stbuf_bus_read_size), .bus_stbuf_data(bus_stbuf_data),
    .bus_stbuf_read_ack(bus_stbuf_read_ack), .stbuf_bus_write_req(stbuf_bus_write_req),
    .stbuf_bus_write_addr(stbuf_bus_write_addr), .stbuf_bus_write_mask(stbuf_bus_write_mask),
    .stbuf_bus_data(stbuf_bus_data), .bus_stbuf_write_ack(bus_stbuf_write_ack),
    .stbuf_all_empty(stbuf_all_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_st(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input logic [6:0] r);
    exlsu_stbuf_push = 1'b1; exlsu_stbuf_write_addr = a; exlsu_stbuf_write_size = s;
    exlsu_stbuf_write_data = d; exlsu_stbuf_rob_id = r;
    tick();
    exlsu_stbuf_push = 1'b0;
  endtask

  task automatic commit4(input logic [6:0] r0, input logic [6:0] r1, input logic [6:0] r2,
                         input logic [6:0] r3, input logic [3:0] v, input logic fl);
    cfp.enable = 1'b1; cfp.flush = fl;
    cfp.committed_rob_id[0] = r0; cfp.committed_rob_id[1] = r1;
    cfp.committed_rob_id[2] = r2; cfp.committed_rob_id[3] = r3;
    cfp.committed_rob_id_valid = v;
    tick();
    cfp = '0;
  endtask

  task automatic drain_wait(output int nwr);
    nwr = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (stbuf_all_empty) break;
      if (stbuf_bus_write_req) nwr++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (stbuf_exlsu_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", stbuf_exlsu_full); end
    checks++; if (stbuf_all_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", stbuf_all_empty); end
    checks++; if (stbuf_misaligned !== 1'b0) begin failures++; $display("FAIL reset_misal got=%b exp=0", stbuf_misaligned); end
    checks++; if (stbuf_bus_write_req !== 1'b0) begin failures++; $display("FAIL reset_wreq got=%b exp=0", stbuf_bus_write_req); end
    checks++; if (stbuf_bus_read_req !== 1'b0) begin failures++; $display("FAIL reset_rreq got=%b exp=0", stbuf_bus_read_req); end
    checks++; if (stbuf_exlsu_bus_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", stbuf_exlsu_bus_ready); end
    checks++; if (stbuf_exlsu_fwd_mask !== 4'h0) begin failures++; $display("FAIL reset_fwd got=%h exp=0", stbuf_exlsu_fwd_mask); end
    checks++; if (stbuf_bus_write_addr !== 32'h0) begin failures++; $display("FAIL reset_waddr got=%h exp=0", stbuf_bus_write_addr); end
    checks++; if (stbuf_exlsu_bus_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", stbuf_exlsu_bus_data); end
    tick();
  endtask

  task automatic test_fill_drain();
    int nwr, idle;
    for (int k = 0; k < 8; k++) push_st(32'h100 + 32'(4*k), 4'd4, 32'hA000_0000 + 32'(k), 7'(k));
    checks++; if (stbuf_exlsu_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", stbuf_exlsu_full); end
    push_st(32'h120, 4'd4, 32'hDEAD_0009, 7'd8);
    checks++; if (stbuf_exlsu_full !== 1'b1) begin failures++; $display("FAIL fill_full9 got=%b exp=1", stbuf_exlsu_full); end
    issue_stbuf_rd = 1'b1; issue_stbuf_read_addr = 32'h120; issue_stbuf_read_size = 4'd4;
    #1;
    checks++; if (stbuf_exlsu_fwd_mask !== 4'h0) begin failures++; $display("FAIL fill_9th_ignored fwd got=%h exp=0", stbuf_exlsu_fwd_mask); end
    issue_stbuf_rd = 1'b0;
    tick();
    commit4(7'd0, 7'd1, 7'd2, 7'd3, 4'hF, 1'b0);
    commit4(7'd4, 7'd5, 7'd6, 7'd7, 4'hF, 1'b0);
    bus_stbuf_write_ack = 1'b1;
    nwr = 0; idle = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stbuf_all_empty) break;
      if (stbuf_bus_write_req) begin
        checks++; if (stbuf_bus_write_addr !== 32'h100 + 32'(4*nwr)) begin failures++; $display("FAIL drain_addr[%0d] got=%h exp=%h", nwr, stbuf_bus_write_addr, 32'h100 + 32'(4*nwr)); end
        checks++; if (stbuf_bus_write_mask !== 4'hF) begin failures++; $display("FAIL drain_mask[%0d] got=%h exp=f", nwr, stbuf_bus_write_mask); end
        nwr++;
      end else idle++;
      tick();
    end
    bus_stbuf_write_ack = 1'b0;
    checks++; if (nwr !== 8) begin failures++; $display("FAIL drain_count got=%0d exp=8", nwr); end
    checks++; if (idle !== 0) begin failures++; $display("FAIL drain_idle_cycles got=%0d exp=0", idle); end
    checks++; if (stbuf_all_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", stbuf_all_empty); end
    tick();
  endtask

  task automatic test_coalesce();
    push_st(32'h201, 4'd1, 32'h0000_00AA, 7'd10);
    push_st(32'h203, 4'd1, 32'h0000_00BB, 7'd11);
    commit4(7'd10, 7'd11, 7'd0, 7'd0, 4'h3, 1'b0);
    checks++; if (stbuf_bus_write_req !== 1'b1) begin failures++; $display("FAIL coal_req got=%b exp=1", stbuf_bus_write_req); end
    checks++; if (stbuf_bus_write_addr !== 32'h200) begin failures++; $display("FAIL coal_addr got=%h exp=200", stbuf_bus_write_addr); end
    checks++; if (stbuf_bus_write_mask !== 4'b1010) begin failures++; $display("FAIL coal_mask got=%b exp=1010", stbuf_bus_write_mask); end
    checks++; if (stbuf_bus_data !== 32'hBB00_AA00) begin failures++; $display("FAIL coal_data got=%h exp=bb00aa00", stbuf_bus_data); end
    bus_stbuf_write_ack = 1'b1;
    tick();
    bus_stbuf_write_ack = 1'b0;
    checks++; if (stbuf_all_empty !== 1'b1) begin failures++; $display("FAIL coal_single_write empty got=%b exp=1", stbuf_all_empty); end
    checks++; if (stbuf_bus_write_req !== 1'b0) begin failures++; $display("FAIL coal_req_after got=%b exp=0", stbuf_bus_write_req); end
    tick();
  endtask

  task automatic test_forward_overlap();
    push_st(32'h300, 4'd4, 32'h1122_3344, 7'd12);
    push_st(32'h302, 4'd2, 32'h0000_5566, 7'd13);
    issue_stbuf_rd = 1'b1; issue_stbuf_read_addr = 32'h300; issue_stbuf_read_size = 4'd4;
    #1;
    checks++; if (stbuf_exlsu_fwd_mask !== 4'hF) begin failures++; $display("FAIL fwd_mask got=%h exp=f", stbuf_exlsu_fwd_mask); end
    checks++; if (stbuf_exlsu_bus_data !== 32'h5566_3344) begin failures++; $display("FAIL fwd_data got=%h exp=55663344", stbuf_exlsu_bus_data); end
    checks++; if (stbuf_exlsu_bus_ready !== 1'b1) begin failures++; $display("FAIL fwd_ready got=%b exp=1", stbuf_exlsu_bus_ready); end
    checks++; if (stbuf_bus_read_req !== 1'b0) begin failures++; $display("FAIL fwd_no_read got=%b exp=0", stbuf_bus_read_req); end
    issue_stbuf_rd = 1'b0;
    tick();
    commit4(7'd0, 7'd0, 7'd0, 7'd0, 4'h0, 1'b1);
    checks++; if (stbuf_all_empty !== 1'b1) begin failures++; $display("FAIL fwd_flush_empty got=%b exp=1", stbuf_all_empty); end
  endtask

  task automatic test_partial_read();
    push_st(32'h401, 4'd1, 32'h0000_0077, 7'd14);
    issue_stbuf_rd = 1'b1; issue_stbuf_read_addr = 32'h400; issue_stbuf_read_size = 4'd4;
    bus_stbuf_data = 32'hDEAD_BEEF; bus_stbuf_read_ack = 1'b0;
    #1;
    checks++; if (stbuf_exlsu_bus_ready !== 1'b0) begin failures++; $display("FAIL part_ready_noack got=%b exp=0", stbuf_exlsu_bus_ready); end
    bus_stbuf_read_ack = 1'b1;
    #1;
    checks++; if (stbuf_bus_read_req !== 1'b1) begin failures++; $display("FAIL part_rreq got=%b exp=1", stbuf_bus_read_req); end
    checks++; if (stbuf_bus_read_addr !== 32'h400) begin failures++; $display("FAIL part_raddr got=%h exp=400", stbuf_bus_read_addr); end
    checks++; if (stbuf_exlsu_fwd_mask !== 4'h2) begin failures++; $display("FAIL part_fwd got=%h exp=2", stbuf_exlsu_fwd_mask); end
    checks++; if (stbuf_exlsu_bus_data !== 32'hDEAD_77EF) begin failures++; $display("FAIL part_data got=%h exp=dead77ef", stbuf_exlsu_bus_data); end
    checks++; if (stbuf_exlsu_bus_ready !== 1'b1) begin failures++; $display("FAIL part_ready got=%b exp=1", stbuf_exlsu_bus_ready); end
    issue_stbuf_rd = 1'b0; bus_stbuf_read_ack = 1'b0; bus_stbuf_data = '0;
    tick();
    commit4(7'd0, 7'd0, 7'd0, 7'd0, 4'h0, 1'b1);
  endtask

  task automatic test_flush();
    int nwr;
    for (int k = 0; k < 4; k++) push_st(32'h600 + 32'(4*k), 4'd4, 32'hF000_0000 + 32'(k), 7'(20 + k));
    exlsu_stbuf_push = 1'b1; exlsu_stbuf_write_addr = 32'h610; exlsu_stbuf_write_size = 4'd4;
    exlsu_stbuf_write_data = 32'h1234_5678; exlsu_stbuf_rob_id = 7'd24;
    commit4(7'd20, 7'd21, 7'd0, 7'd0, 4'h3, 1'b1);
    exlsu_stbuf_push = 1'b0;
    issue_stbuf_rd = 1'b1; issue_stbuf_read_size = 4'd4;
    issue_stbuf_read_addr = 32'h610; #1;
    checks++; if (stbuf_exlsu_fwd_mask !== 4'h0) begin failures++; $display("FAIL flush_push_dropped fwd got=%h exp=0", stbuf_exlsu_fwd_mask); end
    issue_stbuf_read_addr = 32'h608; #1;
    checks++; if (stbuf_exlsu_fwd_mask !== 4'h0) begin failures++; $display("FAIL flush_uncommitted fwd got=%h exp=0", stbuf_exlsu_fwd_mask); end
    issue_stbuf_read_addr = 32'h604; #1;
    checks++; if (stbuf_exlsu_fwd_mask !== 4'hF) begin failures++; $display("FAIL flush_committed fwd got=%h exp=f", stbuf_exlsu_fwd_mask); end
    issue_stbuf_rd = 1'b0;
    checks++; if (stbuf_bus_write_addr !== 32'h600) begin failures++; $display("FAIL flush_waddr got=%h exp=600", stbuf_bus_write_addr); end
    tick();
    bus_stbuf_write_ack = 1'b1;
    drain_wait(nwr);
    bus_stbuf_write_ack = 1'b0;
    checks++; if (nwr !== 2) begin failures++; $display("FAIL flush_writes got=%0d exp=2", nwr); end
    checks++; if (stbuf_all_empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", stbuf_all_empty); end
    tick();
  endtask

  task automatic test_misaligned_reset();
    push_st(32'h502, 4'd4, 32'h0BAD_0BAD, 7'd30);
    checks++; if (stbuf_misaligned !== 1'b1) begin failures++; $display("FAIL misal_pulse got=%b exp=1", stbuf_misaligned); end
    checks++; if (stbuf_all_empty !== 1'b1) begin failures++; $display("FAIL misal_no_entry got=%b exp=1", stbuf_all_empty); end
    tick();
    checks++; if (stbuf_misaligned !== 1'b0) begin failures++; $display("FAIL misal_one_cycle got=%b exp=0", stbuf_misaligned); end
    push_st(32'h500, 4'd4, 32'h1234_5678, 7'd31);
    commit4(7'd31, 7'd0, 7'd0, 7'd0, 4'h1, 1'b0);
    checks++; if (stbuf_bus_write_req !== 1'b1) begin failures++; $display("FAIL rstmid_pending got=%b exp=1", stbuf_bus_write_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (stbuf_bus_write_req !== 1'b0) begin failures++; $display("FAIL rstmid_wreq got=%b exp=0", stbuf_bus_write_req); end
    checks++; if (stbuf_all_empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", stbuf_all_empty); end
    tick();
  endtask

  task automatic test_wrap_coalesce();
    int nwr;
    for (int k = 0; k < 7; k++) push_st(32'h800 + 32'(4*k), 4'd4, 32'(k), 7'(40 + k));
    commit4(7'd40, 7'd41, 7'd42, 7'd43, 4'hF, 1'b0);
    commit4(7'd44, 7'd45, 7'd46, 7'd0, 4'h7, 1'b0);
    bus_stbuf_write_ack = 1'b1;
    drain_wait(nwr);
    bus_stbuf_write_ack = 1'b0;
    checks++; if (nwr !== 7) begin failures++; $display("FAIL wrap_predrain got=%0d exp=7", nwr); end
    tick();
    push_st(32'h700, 4'd1, 32'h0000_0011, 7'd47);
    push_st(32'h702, 4'd1, 32'h0000_0022, 7'd48);
    commit4(7'd47, 7'd48, 7'd0, 7'd0, 4'h3, 1'b0);
    checks++; if (stbuf_bus_write_addr !== 32'h700) begin failures++; $display("FAIL wrap_addr got=%h exp=700", stbuf_bus_write_addr); end
    checks++; if (stbuf_bus_write_mask !== 4'b0101) begin failures++; $display("FAIL wrap_mask got=%b exp=0101", stbuf_bus_write_mask); end
    checks++; if (stbuf_bus_data !== 32'h0022_0011) begin failures++; $display("FAIL wrap_data got=%h exp=00220011", stbuf_bus_data); end
    bus_stbuf_write_ack = 1'b1;
    tick();
    bus_stbuf_write_ack = 1'b0;
    checks++; if (stbuf_all_empty !== 1'b1) begin failures++; $display("FAIL wrap_single_write empty got=%b exp=1", stbuf_all_empty); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    issue_stbuf_rd = 1'b0; issue_stbuf_read_addr = '0; issue_stbuf_read_size = '0;
    exlsu_stbuf_push = 1'b0; exlsu_stbuf_rob_id = '0; exlsu_stbuf_write_addr = '0;
    exlsu_stbuf_write_size = '0; exlsu_stbuf_write_data = '0;
    cfp = '0;
    bus_stbuf_data = '0; bus_stbuf_read_ack = 1'b0; bus_stbuf_write_ack = 1'b0;
    test_reset();
    test_fill_drain();
    test_coalesce();
    test_forward_overlap();
    test_partial_read();
    test_flush();
    test_misaligned_reset();
    test_wrap_coalesce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
